// File: rtl/led_pattern_seq.sv
// LED bank pattern sequencer: flow up/down, ping-pong, blink and off patterns
// advanced by an upstream tick strobe, with a mode strobe and a period-wrap pulse.
module led_pattern_seq #(
    parameter int LED_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             tick,
    input  logic             mode_next,
    input  logic             pause,
    output logic [LED_W-1:0] led_out,
    output logic [2:0]       mode,
    output logic             cycle_done
);

    typedef enum logic [2:0] {
        M_OFF   = 3'd0,
        M_UP    = 3'd1,
        M_DOWN  = 3'd2,
        M_PP    = 3'd3,
        M_BLINK = 3'd4
    } mode_e;

    localparam logic [LED_W-1:0] LSB_ONLY = LED_W'(1);
    localparam logic [LED_W-1:0] MSB_ONLY = {1'b1, {(LED_W-1){1'b0}}};

    mode_e            mode_q, mode_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             dir_q, dir_d;   // ping-pong direction, 1 = moving down
    logic             done_q, done_d;
    logic             tick_ok;

    // A mode change in the same cycle swallows the tick.
    assign tick_ok = tick & ~pause & ~mode_next;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q <= M_UP;
            led_q  <= LSB_ONLY;
            dir_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        dir_d  = dir_q;
        done_d = 1'b0;
        if (mode_next) begin
            dir_d = 1'b0;
            case (mode_q)
                M_OFF:   begin mode_d = M_UP;    led_d = LSB_ONLY; end
                M_UP:    begin mode_d = M_DOWN;  led_d = MSB_ONLY; end
                M_DOWN:  begin mode_d = M_PP;    led_d = LSB_ONLY; end
                M_PP:    begin mode_d = M_BLINK; led_d = '1;       end
                M_BLINK: begin mode_d = M_OFF;   led_d = '0;       end
                default: begin mode_d = M_UP;    led_d = LSB_ONLY; end
            endcase
        end else begin
            case (mode_q)
                M_UP: if (tick_ok) begin
                    led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    done_d = led_q[LED_W-1];
                end
                M_DOWN: if (tick_ok) begin
                    led_d  = {led_q[0], led_q[LED_W-1:1]};
                    done_d = led_q[0];
                end
                M_PP: if (tick_ok) begin
                    if (!dir_q) begin
                        led_d = led_q << 1;
                        if (led_q[LED_W-2]) dir_d = 1'b1;
                    end else begin
                        led_d = led_q >> 1;
                        if (led_q[1]) begin
                            dir_d  = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
                M_BLINK: if (tick_ok) begin
                    led_d  = ~led_q;
                    done_d = (led_q == '0);
                end
                // OFF and the unused encodings keep the bank dark.
                default: led_d = '0;
            endcase
        end
    end

    assign led_out    = led_q;
    assign mode       = mode_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: directed scenarios plus a randomized run against
// a position/phase based reference model.
module tb_led_pattern_seq;

    localparam int W = 4;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         tick = 1'b0;
    logic         mode_next = 1'b0;
    logic         pause = 1'b0;
    logic [W-1:0] led_out;
    logic [2:0]   mode;
    logic         cycle_done;

    int tests = 0;
    int fails = 0;

    led_pattern_seq #(.LED_W(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tick      (tick),
        .mode_next (mode_next),
        .pause     (pause),
        .led_out   (led_out),
        .mode      (mode),
        .cycle_done(cycle_done)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse(input logic t, input logic m);
        tick = t;
        mode_next = m;
        cyc();
        tick = 1'b0;
        mode_next = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        cyc();
        cyc();
        tests++; if (led_out !== 4'b0001) begin fails++; $display("FAIL reset_led: got %b exp 0001", led_out); end
        tests++; if (mode !== 3'd1) begin fails++; $display("FAIL reset_mode: got %0d exp 1", mode); end
        tests++; if (cycle_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", cycle_done); end
        sys_rst = 1'b0;
    endtask

    task automatic test_flow_up();
        logic [W-1:0] exp_led [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic         exp_dn  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            pulse(1'b1, 1'b0);
            tests++; if (led_out !== exp_led[i]) begin fails++; $display("FAIL flow_up_led[%0d]: got %b exp %b", i, led_out, exp_led[i]); end
            tests++; if (cycle_done !== exp_dn[i]) begin fails++; $display("FAIL flow_up_done[%0d]: got %b exp %b", i, cycle_done, exp_dn[i]); end
        end
    endtask

    task automatic test_mode_cycle();
        logic [2:0]   exp_m   [5] = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        logic [W-1:0] exp_led [5] = '{4'b1000, 4'b0001, 4'b1111, 4'b0000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            pulse(1'b0, 1'b1);
            tests++; if (mode !== exp_m[i]) begin fails++; $display("FAIL mode_cycle_mode[%0d]: got %0d exp %0d", i, mode, exp_m[i]); end
            tests++; if (led_out !== exp_led[i]) begin fails++; $display("FAIL mode_cycle_led[%0d]: got %b exp %b", i, led_out, exp_led[i]); end
            tests++; if (cycle_done !== 1'b0) begin fails++; $display("FAIL mode_cycle_done[%0d]: got %b exp 0", i, cycle_done); end
        end
    endtask

    task automatic test_pingpong();
        logic [W-1:0] exp_led [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        logic         exp_dn  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        tests++; if (mode !== 3'd3) begin fails++; $display("FAIL pp_mode: got %0d exp 3", mode); end
        for (int i = 0; i < 7; i++) begin
            pulse(1'b1, 1'b0);
            tests++; if (led_out !== exp_led[i]) begin fails++; $display("FAIL pp_led[%0d]: got %b exp %b", i, led_out, exp_led[i]); end
            tests++; if (cycle_done !== exp_dn[i]) begin fails++; $display("FAIL pp_done[%0d]: got %b exp %b", i, cycle_done, exp_dn[i]); end
        end
    endtask

    task automatic test_pause_collision();
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1);   // PP -> BLINK -> OFF -> UP -> DOWN
        tests++; if (mode !== 3'd2 || led_out !== 4'b1000) begin fails++; $display("FAIL pc_down_start: got mode %0d led %b exp 2/1000", mode, led_out); end
        pulse(1'b1, 1'b0);
        tests++; if (led_out !== 4'b0100) begin fails++; $display("FAIL pc_first_tick: got %b exp 0100", led_out); end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            tests++; if (led_out !== 4'b0100 || cycle_done !== 1'b0) begin fails++; $display("FAIL pc_paused[%0d]: got %b/%b exp 0100/0", i, led_out, cycle_done); end
        end
        pause = 1'b0;
        pulse(1'b1, 1'b0);
        tests++; if (led_out !== 4'b0010) begin fails++; $display("FAIL pc_resume: got %b exp 0010", led_out); end
        pulse(1'b1, 1'b1);
        tests++; if (mode !== 3'd3) begin fails++; $display("FAIL pc_coll_mode: got %0d exp 3", mode); end
        tests++; if (led_out !== 4'b0001) begin fails++; $display("FAIL pc_coll_led: got %b exp 0001", led_out); end
        tests++; if (cycle_done !== 1'b0) begin fails++; $display("FAIL pc_coll_done: got %b exp 0", cycle_done); end
    endtask

    task automatic test_blink_reset();
        logic [W-1:0] exp_led [3] = '{4'b0000, 4'b1111, 4'b0000};
        logic         exp_dn  [3] = '{1'b0, 1'b1, 1'b0};
        pulse(1'b0, 1'b1);
        tests++; if (mode !== 3'd4 || led_out !== 4'b1111) begin fails++; $display("FAIL blink_start: got mode %0d led %b exp 4/1111", mode, led_out); end
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            tests++; if (led_out !== exp_led[i]) begin fails++; $display("FAIL blink_led[%0d]: got %b exp %b", i, led_out, exp_led[i]); end
            tests++; if (cycle_done !== exp_dn[i]) begin fails++; $display("FAIL blink_done[%0d]: got %b exp %b", i, cycle_done, exp_dn[i]); end
        end
        #4;
        sys_rst = 1'b1;
        #1;
        tests++; if (led_out !== 4'b0001) begin fails++; $display("FAIL async_rst_led: got %b exp 0001", led_out); end
        tests++; if (mode !== 3'd1) begin fails++; $display("FAIL async_rst_mode: got %0d exp 1", mode); end
        tests++; if (cycle_done !== 1'b0) begin fails++; $display("FAIL async_rst_done: got %b exp 0", cycle_done); end
        #3;
        sys_rst = 1'b0;
        pulse(1'b1, 1'b0);
        tests++; if (led_out !== 4'b0010) begin fails++; $display("FAIL post_rst_tick: got %b exp 0010", led_out); end
    endtask

    // Reference model: mode number plus a position/phase index k.
    // FLOW_UP/FLOW_DOWN: k is the lit bit; PINGPONG: k is the phase in a
    // 2*(W-1) period; BLINK: k = 1 means all lit.
    function automatic logic [W-1:0] model_led(input int mm, input int k);
        logic [W-1:0] one;
        one = W'(1);
        case (mm)
            1, 2:    return one << k;
            3:       return one << ((k < W) ? k : 2 * (W - 1) - k);
            4:       return (k != 0) ? '1 : '0;
            default: return '0;
        endcase
    endfunction

    task automatic test_random();
        int   mm, k;
        logic ex_done;
        logic t, m, p;
        sys_rst = 1'b1;
        cyc();
        sys_rst = 1'b0;
        mm = 1; k = 0; ex_done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            t = ($urandom_range(0, 1) == 1);
            m = ($urandom_range(0, 9) == 0);
            p = ($urandom_range(0, 4) == 0);
            tick = t; mode_next = m; pause = p;
            cyc();
            ex_done = 1'b0;
            if (m) begin
                mm = (mm == 4) ? 0 : mm + 1;
                k  = (mm == 2) ? W - 1 : ((mm == 4) ? 1 : 0);
            end else if (t && !p) begin
                case (mm)
                    1: begin k = (k + 1) % W;           ex_done = (k == 0);     end
                    2: begin k = (k + W - 1) % W;       ex_done = (k == W - 1); end
                    3: begin k = (k + 1) % (2 * (W-1)); ex_done = (k == 0);     end
                    4: begin k = 1 - k;                 ex_done = (k == 1);     end
                    default: ;
                endcase
            end
            tests++; if (mode !== 3'(mm)) begin fails++; $display("FAIL rand_mode[%0d]: got %0d exp %0d", n, mode, mm); end
            tests++; if (led_out !== model_led(mm, k)) begin fails++; $display("FAIL rand_led[%0d]: got %b exp %b", n, led_out, model_led(mm, k)); end
            tests++; if (cycle_done !== ex_done) begin fails++; $display("FAIL rand_done[%0d]: got %b exp %b", n, cycle_done, ex_done); end
        end
        tick = 1'b0; mode_next = 1'b0; pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_flow_up();
        test_mode_cycle();
        test_pingpong();
        test_pause_collision();
        test_blink_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

- Pattern sequencer for an LED bank.
- Sits directly downstream of the team's free-running period counter, which supplies a one-cycle `tick` strobe.
- Each accepted tick advances the active pattern: flow up, flow down, ping-pong, blink or off.
- A debounced mode strobe cycles through the patterns. A registered `cycle_done` pulse marks each completed pattern period.

## Interface
- `LED_W`, default 4: number of LEDs. Legal range is 2..16.
- `sys_clk`, input, 1: system clock (50 MHz).
- `sys_rst`, input, 1: asynchronous, active-high reset.
- `tick`, input, 1: advance strobe, nominally one cycle wide. Every cycle it is high counts as one tick.
- `mode_next`, input, 1: one-cycle strobe that selects the next mode. Already debounced upstream.
- `pause`, input, 1: level signal. While high, ticks are ignored.
- `led_out`, output, LED_W: registered LED drive, 1 = lit.
- `mode`, output, 3: registered current mode.
- `cycle_done`, output, 1: registered one-cycle pulse at each pattern wrap.

## Operation
Mode encodings:
- 0 = OFF
- 1 = FLOW_UP
- 2 = FLOW_DOWN
- 3 = PINGPONG
- 4 = BLINK

Reset values (applied immediately on `sys_rst` high, including mid-pattern):
- `mode` = 1 (FLOW_UP)
- `led_out` = 1 (bit 0 lit)
- internal direction = up
- `cycle_done` = 0

Mode change:
- `mode_next` high at a rising edge moves `mode` to the next value: 0→1→2→3→4→0.
- At the same edge, `led_out` loads the new mode's start pattern:
  - OFF: all zero
  - FLOW_UP: bit 0
  - FLOW_DOWN: bit LED_W-1
  - PINGPONG: bit 0, direction up
  - BLINK: all ones
- `cycle_done` = 0 on a mode-change edge.

Mode 5..7 (fault only):
- Behaves as OFF: `led_out` = 0, ticks have no effect.
- The next `mode_next` goes to 1.

Tick accepted when `tick` = 1, `pause` = 0 and `mode_next` = 0:
- **FLOW_UP:** rotate left; bit LED_W-1 wraps to bit 0. `cycle_done` = 1 on the wrap edge.
- **FLOW_DOWN:** rotate right; bit 0 wraps to bit LED_W-1. `cycle_done` = 1 on the wrap edge.
- **PINGPONG:**
  - Shift in the current direction.
  - Direction flips to down when the lit bit reaches LED_W-1, and back to up when it reaches bit 0.
  - There is no wrap and no double-lit state.
  - Period is 2·(LED_W-1) ticks.
  - `cycle_done` = 1 on the edge where the lit bit moves from bit 1 to bit 0.
- **BLINK:** invert all bits. `cycle_done` = 1 on the edge where `led_out` goes from zero to all ones (period 2 ticks).
- **OFF:** `led_out` stays 0; `cycle_done` never asserts.

Other conditions:
- Exactly one LED is lit at all times in FLOW_UP, FLOW_DOWN and PINGPONG.
- No tick accepted: `led_out` holds and `cycle_done` = 0.
- `pause` does not block `mode_next`.
- Pausing freezes the pattern and the ping-pong direction; advance resumes from the same state.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Tick latency: a tick sampled at edge N gives the new `led_out` and `cycle_done` visible after edge N.
- `cycle_done` is high for exactly the one cycle following that edge.
- Mode-change latency: `mode` and `led_out` update at the edge that samples `mode_next`.
- `tick` and `mode_next` high together: the mode change wins and the tick is dropped (no advance, no `cycle_done`).
- `tick` held high for k cycles: the pattern advances k times.
- Reset deassertion: the first tick can be accepted at the first rising edge after `sys_rst` falls.

## Test plan
All scenarios use LED_W = 4.
1. **Reset, FLOW_UP:** release reset, then 5 single ticks (each 1 cycle).
   - `led_out` = 0001 → 0010, 0100, 1000, 0001, 0010.
   - `cycle_done` pulses once, after the 4th tick.
2. **Mode cycling:** 5 `mode_next` strobes with no ticks.
   - `mode` = 2, 3, 4, 0, 1.
   - `led_out` = 1000, 0001, 1111, 0000, 0001.
3. **PINGPONG:** select mode 3, then 7 ticks.
   - `led_out` = 0010, 0100, 1000, 0100, 0010, 0001, 0010.
   - `cycle_done` pulses exactly once, after the 6th tick.
4. **Pause and collision:** FLOW_DOWN at 0100.
   - Hold `pause` and send 3 ticks → stays 0100.
   - Release `pause`, tick → 0010.
   - Assert `tick` and `mode_next` in the same cycle → `mode` = 3, `led_out` = 0001, `cycle_done` = 0.
5. **BLINK, then reset mid-pattern:** BLINK, 3 ticks.
   - `led_out` = 0000, 1111, 0000.
   - `cycle_done` pulses after the 2nd tick.
   - Assert `sys_rst` asynchronously between clock edges → `led_out` = 0001, `mode` = 1, `cycle_done` = 0 immediately.
